// File: rtl/ram_spi_pkg.sv
// Shared command encoding for the SPI-facing single-port RAM.
package ram_spi_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

endpackage

// File: rtl/ram_spi.sv
// Command-driven RAM: separate write/read address registers, registered read data
// with a valid flag that holds until the next accepted command.
module ram_spi
    import ram_spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid
);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] payload;
    op_e                  op;

    assign op      = op_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload = din[ADDR_SIZE-1:0];

    // Address registers and read port; mem itself is deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else if (rx_valid) begin
            case (op)
                OP_WR_ADDR: begin
                    wr_addr  <= payload;
                    tx_valid <= 1'b0;
                end
                OP_WR_DATA: begin
                    tx_valid <= 1'b0;
                end
                OP_RD_ADDR: begin
                    rd_addr  <= payload;
                    tx_valid <= 1'b0;
                end
                OP_RD_DATA: begin
                    dout     <= mem[rd_addr];
                    tx_valid <= 1'b1;
                end
            endcase
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (rx_valid && op == OP_WR_DATA) begin
            mem[wr_addr] <= payload;
        end
    end

endmodule

// File: tb/tb_ram_spi.sv
// Self-checking bench for ram_spi: directed vector table, reset corner cases,
// and a scoreboarded random write/read soak against a reference memory.
module tb_ram_spi;
    import ram_spi_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned SOAK  = 10000;

    logic [AW+1:0] din;
    logic          rx_valid;
    logic          clk;
    logic          rst_n;
    logic [AW-1:0] dout;
    logic          tx_valid;

    ram_spi #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut (
        .din      (din),
        .rx_valid (rx_valid),
        .clk      (clk),
        .rst_n    (rst_n),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] pl;
        logic          v;
        logic [AW-1:0] exp_dout;
        logic          exp_tx;
    } vec_t;

    typedef struct {
        logic [AW-1:0] data;
        logic [AW-1:0] addr;
    } sb_t;

    logic [AW-1:0] model [DEPTH];
    vec_t          vecs[$];
    sb_t           sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One command per cycle: drive at negedge, outputs settle 1 time unit after posedge.
    task automatic cmd(input logic [1:0] op, input logic [AW-1:0] pl, input logic v);
        @(negedge clk);
        din      = {op, pl};
        rx_valid = v;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic read_sb(input logic [AW-1:0] a);
        cmd(OP_RD_ADDR, a, 1'b1);
        sb_q.push_back('{data: model[a], addr: a});
        cmd(OP_RD_DATA, 8'h00, 1'b1);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("soak_tx_valid", 32'(tx_valid), 32'd1);
            check("soak_dout", 32'(dout), 32'(e.data));
        end
    endtask

    initial begin
        din      = '0;
        rx_valid = 1'b0;
        rst_n    = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) model[i] = AW'($urandom);
        model[8'h00] = 8'h5A;
        model[8'h05] = 8'hA5;
        model[8'hFF] = 8'h11;
        for (int i = 0; i < int'(DEPTH); i++) dut.mem[i] = model[i];

        // Reset state with preloaded memory
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mem5", 32'(dut.mem[5]), 32'hA5);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        vecs.push_back('{OP_WR_ADDR, 8'h3C, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{OP_WR_DATA, 8'h7E, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{OP_RD_ADDR, 8'h3C, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{OP_RD_DATA, 8'hC3, 1'b1, 8'h7E, 1'b1});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b0, 8'h7E, 1'b1});
        vecs.push_back('{OP_RD_ADDR, 8'h00, 1'b1, 8'h7E, 1'b0});
        vecs.push_back('{OP_WR_DATA, 8'h99, 1'b0, 8'h7E, 1'b0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 8'h5A, 1'b1});
        vecs.push_back('{OP_RD_ADDR, 8'h05, 1'b1, 8'h5A, 1'b0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 8'hA5, 1'b1});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 8'hA5, 1'b1});
        vecs.push_back('{OP_WR_ADDR, 8'h10, 1'b1, 8'hA5, 1'b0});
        vecs.push_back('{OP_RD_ADDR, 8'hFF, 1'b1, 8'hA5, 1'b0});
        vecs.push_back('{OP_WR_DATA, 8'h22, 1'b1, 8'hA5, 1'b0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 8'h11, 1'b1});
        vecs.push_back('{OP_RD_ADDR, 8'h10, 1'b1, 8'h11, 1'b0});
        vecs.push_back('{OP_RD_DATA, 8'h00, 1'b1, 8'h22, 1'b1});
        model[8'h3C] = 8'h7E;
        model[8'h10] = 8'h22;

        foreach (vecs[i]) begin
            cmd(vecs[i].op, vecs[i].pl, vecs[i].v);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_tx));
        end
        check("gated_write_mem3c", 32'(dut.mem[8'h3C]), 32'h7E);
        check("indep_mem10", 32'(dut.mem[8'h10]), 32'h22);

        // Asynchronous reset mid-sequence discards latched addresses
        cmd(OP_WR_ADDR, 8'h40, 1'b1);
        cmd(OP_RD_ADDR, 8'h40, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout), 32'd0);
        check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(OP_WR_DATA, 8'h77, 1'b1);
        model[8'h00] = 8'h77;
        cmd(OP_RD_DATA, 8'h00, 1'b1);
        check("post_rst_read0", 32'(dout), 32'h77);
        check("post_rst_tx_valid", 32'(tx_valid), 32'd1);
        check("post_rst_mem40", 32'(dut.mem[8'h40]), 32'(model[8'h40]));
        check("post_rst_mem5", 32'(dut.mem[5]), 32'hA5);

        // Random soak: writes first, then scoreboarded reads
        for (int i = 0; i < int'(SOAK); i++) begin
            logic [AW-1:0] a, d;
            a = AW'($urandom);
            d = AW'($urandom);
            cmd(OP_WR_ADDR, a, 1'b1);
            cmd(OP_WR_DATA, d, 1'b1);
            model[a] = d;
        end
        for (int i = 0; i < int'(SOAK); i++) begin
            read_sb(AW'($urandom));
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_spi.md
RAM_SPI -- requirements
Module: ram_spi

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of memory words.
REQ-002 Parameter ADDR_SIZE, default 8: address width and data word width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port order SHALL be din, rx_valid, clk, rst_n, dout, tx_valid.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  ADDR_SIZE+2  [ADDR_SIZE+1:ADDR_SIZE] = opcode; [ADDR_SIZE-1:0] = address or data payload.
- rx_valid  input  1  din is valid this cycle.
- dout  output  ADDR_SIZE  read data.
- tx_valid  output  1  dout holds valid read data.

Function
REQ-005 Storage SHALL be a register array named mem, MEM_DEPTH x ADDR_SIZE bits, so that a bench can preload it hierarchically.
REQ-006 din and rx_valid SHALL be sampled on the rising edge of clk; the block ignores din while rx_valid=0.
REQ-007 Opcode 00 SHALL latch payload into the write-address register wr_addr.
REQ-008 Opcode 01 SHALL write payload to mem[wr_addr] at that edge; wr_addr is unchanged.
REQ-009 Opcode 10 SHALL latch payload into the read-address register rd_addr, which is separate from wr_addr.
REQ-010 Opcode 11 SHALL register dout <= mem[rd_addr] and tx_valid <= 1 at that edge, giving 1-cycle latency; the payload is ignored.
REQ-011 tx_valid and dout SHALL hold until the next accepted command; an accepted opcode 00, 01 or 10 SHALL clear tx_valid, and dout SHALL keep its last value.
REQ-012 Back-to-back opcode 11 commands SHALL each reload dout and keep tx_valid=1.
REQ-013 Opcode 01 with no prior opcode 00 since reset SHALL write to address 0.
REQ-014 Opcode 11 with no prior opcode 10 since reset SHALL read address 0.
REQ-015 Read-after-write to the same address SHALL return the new data when opcode 11 arrives at least one cycle after the opcode 01.
REQ-016 Addresses SHALL cover the full range 0..MEM_DEPTH-1 with no wrap logic needed.
REQ-017 There SHALL be no combinational path from din or rx_valid to the outputs.

Reset
REQ-018 While rst_n=0: dout=0, tx_valid=0, wr_addr=0, rd_addr=0, asynchronously.
REQ-019 Reset SHALL NOT clear mem; preloaded and written contents survive reset.
REQ-020 Reset asserted mid-sequence SHALL discard latched addresses; after release, operation restarts per REQ-013/014.

Structure
REQ-021 Opcode constants SHALL live in a shared package: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
REQ-022 The block SHALL be a single module with no sub-module; the decoder SHALL be a case statement on the opcode.

Verification
REQ-023 Reset: hold rst_n=0 with rx_valid=0 -> dout=0 and tx_valid=0; preloaded mem[5]=8'hA5 is unchanged.
REQ-024 Write then read: 00/0x3C, 01/0x7E, 10/0x3C, 11/any (each with rx_valid=1, one per cycle) -> one edge after the 11 command, dout=0x7E and tx_valid=1, held after rx_valid drops.
REQ-025 Clear on next command: after REQ-024, accept 10/0x00 -> tx_valid=0 and dout stays 0x7E.
REQ-026 Independent addresses: wr_addr=0x10, rd_addr=0xFF (mem[0xFF]=0x11), then 01/0x22 and 11 -> dout=0x11, mem[0x10]=0x22.
REQ-027 rx_valid=0 gating: present 01/0x99 with rx_valid=0 -> mem unchanged and outputs unchanged.
REQ-028 Random soak: 10000 random write pairs, then 10000 random reads, checked against a reference model -> every read has tx_valid=1 and matching dout.
